// File: rtl/target_vector_applier_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | target_vector_applier_pkg : FSM encoding and word field offsets |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
package target_vector_applier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    PUSH = 2'd3
  } state_t;

  localparam int STF_WIDTH_DEF   = 24;
  localparam int RTF_WIDTH_DEF   = 24;
  localparam int CYCLE_RANGE_DEF = 5;
  localparam int CNT_WIDTH_DEF   = 16;

  // Hold field sits directly above the vector / result field.
  localparam int HOLD_LSB     = STF_WIDTH_DEF;
  localparam int RES_HOLD_LSB = RTF_WIDTH_DEF;

endpackage
`default_nettype wire

// File: rtl/target_vector_applier.sv
`default_nettype none
// +----------------------------------------------------------------+
// | target_vector_applier : applies stimulus words, pushes results  |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module target_vector_applier
  import target_vector_applier_pkg::*;
#(
  parameter int STF_WIDTH   = STF_WIDTH_DEF,
  parameter int RTF_WIDTH   = RTF_WIDTH_DEF,
  parameter int CYCLE_RANGE = CYCLE_RANGE_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               enable,
  output logic                               busy,
  output logic                               sfifo_rdreq,
  input  logic                               sfifo_rdempty,
  input  logic [STF_WIDTH+CYCLE_RANGE:0]     sfifo_dataq,
  output logic [RTF_WIDTH+CYCLE_RANGE:0]     rfifo_data,
  output logic                               rfifo_wrreq,
  input  logic                               rfifo_wrfull,
  output logic [STF_WIDTH-1:0]               target_in,
  input  logic [RTF_WIDTH-1:0]               target_out,
  output logic [CNT_WIDTH-1:0]               vec_count
);

  localparam int HOLD_W = CYCLE_RANGE + 1;
  localparam logic [HOLD_W-1:0]    HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_echo;

  // Reset gates the request so no pop can be issued while reset is held.
  assign sfifo_rdreq = (state == IDLE) & enable & ~sfifo_rdempty & ~reset;
  assign rfifo_wrreq = (state == PUSH) & ~rfifo_wrfull;
  assign busy        = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      target_in  <= '0;
      rfifo_data <= '0;
      vec_count  <= '0;
      hold_cnt   <= '0;
      hold_echo  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sfifo_rdreq) state <= LOAD;
        end
        LOAD: begin
          target_in <= sfifo_dataq[STF_WIDTH-1:0];
          hold_cnt  <= sfifo_dataq[STF_WIDTH +: HOLD_W];
          hold_echo <= sfifo_dataq[STF_WIDTH +: HOLD_W];
          state     <= HOLD;
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            rfifo_data <= {hold_echo, target_out};
            state      <= PUSH;
          end else begin
            hold_cnt <= hold_cnt - HOLD_ONE;
          end
        end
        PUSH: begin
          // Stall here while the result FIFO is full; result stays registered.
          if (!rfifo_wrfull) begin
            vec_count <= vec_count + CNT_ONE;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_target_vector_applier.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_target_vector_applier : self-checking bench with FIFO models |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module tb_target_vector_applier;

  localparam int STF = 24;
  localparam int RTF = 24;
  localparam int CR  = 5;
  localparam int CW  = 16;
  localparam int HIST = 16384;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              busy;
  logic              sfifo_rdreq;
  logic              sfifo_rdempty = 1'b1;
  logic [STF+CR:0]   sfifo_dataq = '0;
  logic [RTF+CR:0]   rfifo_data;
  logic              rfifo_wrreq;
  logic              rfifo_wrfull = 1'b0;
  logic [STF-1:0]    target_in;
  logic [RTF-1:0]    target_out;
  logic [CW-1:0]     vec_count;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int proto_err = 0;

  logic            tout_fixed_en = 1'b0;
  logic [RTF-1:0]  tout_fixed = '0;
  logic            rand_full_en = 1'b0;

  logic [STF+CR:0] stim_q[$];
  int              rd_cyc_q[$];
  int              wr_cyc_q[$];
  logic [RTF+CR:0] wr_data_q[$];
  logic [STF-1:0]  tin_hist [HIST];

  target_vector_applier dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .busy          (busy),
    .sfifo_rdreq   (sfifo_rdreq),
    .sfifo_rdempty (sfifo_rdempty),
    .sfifo_dataq   (sfifo_dataq),
    .rfifo_data    (rfifo_data),
    .rfifo_wrreq   (rfifo_wrreq),
    .rfifo_wrfull  (rfifo_wrfull),
    .target_in     (target_in),
    .target_out    (target_out),
    .vec_count     (vec_count)
  );

  always #5 clock = ~clock;

  // Target model: output is a known function of the cycle number, so the
  // sampled result pins down exactly which cycle the DUT captured.
  function automatic logic [RTF-1:0] tout_of(input int k);
    logic [31:0] x;
    x = k * 32'h9E3779B1;
    return x[31:8] ^ 24'h5A5A5A;
  endfunction

  assign target_out = tout_fixed_en ? tout_fixed : tout_of(cyc);

  // FIFO models and protocol monitor.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (cyc < HIST) tin_hist[cyc] <= target_in;
    if (sfifo_rdreq) begin
      rd_cyc_q.push_back(cyc);
      if (stim_q.size() == 0) proto_err <= proto_err + 1;
      else sfifo_dataq <= stim_q.pop_front();
      if (busy) proto_err <= proto_err + 1;
    end
    if (rfifo_wrreq) begin
      wr_cyc_q.push_back(cyc);
      wr_data_q.push_back(rfifo_data);
      if (rfifo_wrfull || !busy) proto_err <= proto_err + 1;
    end
  end

  always @(negedge clock) begin
    sfifo_rdempty = (stim_q.size() == 0);
    if (rand_full_en) rfifo_wrfull = ($urandom_range(0, 3) == 0);
  end

  task automatic clear_logs();
    rd_cyc_q.delete();
    wr_cyc_q.delete();
    wr_data_q.delete();
  endtask

  task automatic wait_writes(input int n, input int budget, output bit timed_out);
    int k;
    k = 0;
    timed_out = 1'b0;
    while (wr_data_q.size() < n) begin
      if (k >= budget) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clock);
      k++;
    end
  endtask

  task automatic wait_pop(input int n, input int budget, output bit timed_out);
    int k;
    k = 0;
    timed_out = 1'b0;
    while (rd_cyc_q.size() < n) begin
      if (k >= budget) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clock);
      k++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (sfifo_rdreq !== 1'b0) begin fails++; $display("FAIL reset_rdreq: got %b want 0", sfifo_rdreq); end
    checks++; if (rfifo_wrreq !== 1'b0) begin fails++; $display("FAIL reset_wrreq: got %b want 0", rfifo_wrreq); end
    checks++; if (target_in !== '0) begin fails++; $display("FAIL reset_target_in: got %h want 0", target_in); end
    checks++; if (rfifo_data !== '0) begin fails++; $display("FAIL reset_rfifo_data: got %h want 0", rfifo_data); end
    checks++; if (vec_count !== '0) begin fails++; $display("FAIL reset_vec_count: got %0d want 0", vec_count); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single();
    bit to;
    int t;
    clear_logs();
    tout_fixed_en = 1'b1;
    tout_fixed = 24'h00FF00;
    enable = 1'b1;
    stim_q.push_back({6'd0, 24'hA5A5A5});
    wait_writes(1, 30, to);
    checks++;
    if (to || rd_cyc_q.size() != 1) begin
      fails++; $display("FAIL single_timeout: got %0d writes want 1", wr_data_q.size());
    end else begin
      t = rd_cyc_q[0];
      checks++; if (wr_cyc_q[0] != t + 3) begin fails++; $display("FAIL single_latency: got %0d want %0d", wr_cyc_q[0], t + 3); end
      checks++; if (wr_data_q[0] !== {6'd0, 24'h00FF00}) begin fails++; $display("FAIL single_data: got %h want %h", wr_data_q[0], {6'd0, 24'h00FF00}); end
      checks++; if (tin_hist[t+2] !== 24'hA5A5A5 || tin_hist[t+1] !== 24'h0) begin
        fails++; $display("FAIL single_target_in: got %h/%h want 000000/a5a5a5", tin_hist[t+1], tin_hist[t+2]);
      end
    end
    checks++; if (vec_count !== 16'd1) begin fails++; $display("FAIL single_vec_count: got %0d want 1", vec_count); end
    tout_fixed_en = 1'b0;
  endtask

  task automatic test_hold_max();
    bit to;
    int t, bad;
    logic [STF-1:0] v;
    clear_logs();
    v = $urandom();
    stim_q.push_back({6'd63, v});
    wait_writes(1, 120, to);
    checks++;
    if (to || rd_cyc_q.size() != 1) begin
      fails++; $display("FAIL holdmax_timeout: got %0d writes want 1", wr_data_q.size());
    end else begin
      t = rd_cyc_q[0];
      bad = 0;
      for (int i = t + 2; i <= t + 65; i++) if (tin_hist[i] !== v) bad++;
      checks++; if (wr_cyc_q[0] != t + 66) begin fails++; $display("FAIL holdmax_latency: got %0d want %0d", wr_cyc_q[0], t + 66); end
      checks++; if (bad != 0) begin fails++; $display("FAIL holdmax_stable: got %0d unstable cycles want 0", bad); end
      checks++; if (wr_data_q[0] !== {6'd63, tout_of(t + 65)}) begin
        fails++; $display("FAIL holdmax_data: got %h want %h", wr_data_q[0], {6'd63, tout_of(t + 65)});
      end
    end
    checks++; if (vec_count !== 16'd2) begin fails++; $display("FAIL holdmax_vec_count: got %0d want 2", vec_count); end
  endtask

  task automatic test_wrfull();
    bit to;
    int t, bad, rel;
    logic [STF-1:0] v;
    clear_logs();
    v = $urandom();
    rfifo_wrfull = 1'b1;
    stim_q.push_back({6'd3, v});
    wait_pop(1, 20, to);
    checks++;
    if (to) begin
      fails++; $display("FAIL wrfull_pop_timeout: got 0 pops want 1");
      rfifo_wrfull = 1'b0;
    end else begin
      t = rd_cyc_q[0];
      rel = t + 3 + 3 + 10;
      while (cyc < rel) @(negedge clock);
      checks++; if (wr_data_q.size() != 0) begin fails++; $display("FAIL wrfull_stall: got %0d writes want 0", wr_data_q.size()); end
      rfifo_wrfull = 1'b0;
      wait_writes(1, 5, to);
      repeat (5) @(negedge clock);
      checks++;
      if (to || wr_data_q.size() != 1) begin
        fails++; $display("FAIL wrfull_write_count: got %0d want 1", wr_data_q.size());
      end else begin
        bad = 0;
        for (int i = t + 2; i <= rel; i++) if (tin_hist[i] !== v) bad++;
        checks++; if (wr_cyc_q[0] != rel) begin fails++; $display("FAIL wrfull_release: got %0d want %0d", wr_cyc_q[0], rel); end
        checks++; if (wr_data_q[0] !== {6'd3, tout_of(t + 5)}) begin
          fails++; $display("FAIL wrfull_data: got %h want %h", wr_data_q[0], {6'd3, tout_of(t + 5)});
        end
        checks++; if (bad != 0) begin fails++; $display("FAIL wrfull_target_hold: got %0d changed cycles want 0", bad); end
      end
    end
    checks++; if (vec_count !== 16'd3) begin fails++; $display("FAIL wrfull_vec_count: got %0d want 3", vec_count); end
  endtask

  task automatic test_empty();
    clear_logs();
    enable = 1'b1;
    repeat (20) @(negedge clock);
    checks++; if (rd_cyc_q.size() != 0) begin fails++; $display("FAIL empty_rdreq: got %0d pops want 0", rd_cyc_q.size()); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL empty_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int t;
    clear_logs();
    stim_q.push_back({6'd20, 24'h3C3C3C});
    wait_pop(1, 20, to);
    checks++;
    if (to) begin
      fails++; $display("FAIL rstmid_pop_timeout: got 0 pops want 1");
    end else begin
      t = rd_cyc_q[0];
      while (cyc < t + 12) @(negedge clock);
      checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
      reset = 1'b1;
      #1;
      checks++; if ({busy, sfifo_rdreq, rfifo_wrreq} !== 3'b000) begin
        fails++; $display("FAIL rstmid_ctrl: got %b want 000", {busy, sfifo_rdreq, rfifo_wrreq});
      end
      checks++; if (target_in !== '0 || rfifo_data !== '0 || vec_count !== '0) begin
        fails++; $display("FAIL rstmid_data: got %h/%h/%0d want 0/0/0", target_in, rfifo_data, vec_count);
      end
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (40) @(negedge clock);
      checks++; if (wr_data_q.size() != 0) begin fails++; $display("FAIL rstmid_no_write: got %0d writes want 0", wr_data_q.size()); end
      checks++; if (vec_count !== '0) begin fails++; $display("FAIL rstmid_vec_count: got %0d want 0", vec_count); end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int t;
    logic [STF-1:0] v[3];
    clear_logs();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v[i] = $urandom();
      stim_q.push_back({6'd2, v[i]});
    end
    wait_pop(1, 20, to);
    if (!to) begin
      t = rd_cyc_q[0];
      while (cyc < t + 8) @(negedge clock);
      enable = 1'b0;
      wait_writes(2, 40, to);
      repeat (20) @(negedge clock);
    end
    checks++;
    if (to || wr_data_q.size() != 2 || rd_cyc_q.size() != 2) begin
      fails++; $display("FAIL b2b_counts: got %0d pops %0d writes want 2 2", rd_cyc_q.size(), wr_data_q.size());
    end else begin
      checks++; if (rd_cyc_q[1] != wr_cyc_q[0] + 1) begin fails++; $display("FAIL b2b_refetch: got %0d want %0d", rd_cyc_q[1], wr_cyc_q[0] + 1); end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (wr_cyc_q[i] != rd_cyc_q[i] + 5 || wr_data_q[i] !== {6'd2, tout_of(rd_cyc_q[i] + 4)}
            || tin_hist[rd_cyc_q[i] + 2] !== v[i]) begin
          fails++; $display("FAIL b2b_vec%0d: got %h@%0d want %h@%0d", i, wr_data_q[i], wr_cyc_q[i],
                            {6'd2, tout_of(rd_cyc_q[i] + 4)}, rd_cyc_q[i] + 5);
        end
      end
    end
    checks++; if (stim_q.size() != 1) begin fails++; $display("FAIL b2b_third_left: got %0d queued want 1", stim_q.size()); end
    checks++; if (vec_count !== 16'd2) begin fails++; $display("FAIL b2b_vec_count: got %0d want 2", vec_count); end
    stim_q.delete();
    @(negedge clock);
  endtask

  task automatic test_random();
    localparam int N = 24;
    bit to;
    logic [CR:0]    h[N];
    logic [STF-1:0] v[N];
    logic [RTF+CR:0] exp_word;
    int base;
    clear_logs();
    base = int'(vec_count);
    for (int i = 0; i < N; i++) begin
      h[i] = 6'($urandom_range(0, 15));
      v[i] = $urandom();
      stim_q.push_back({h[i], v[i]});
    end
    enable = 1'b1;
    rand_full_en = 1'b1;
    wait_writes(N, 3000, to);
    rand_full_en = 1'b0;
    @(negedge clock);
    rfifo_wrfull = 1'b0;
    repeat (5) @(negedge clock);
    checks++;
    if (to || wr_data_q.size() != N || rd_cyc_q.size() != N) begin
      fails++; $display("FAIL rand_counts: got %0d writes want %0d", wr_data_q.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        exp_word = {h[i], tout_of(rd_cyc_q[i] + 2 + int'(h[i]))};
        checks++;
        if (wr_data_q[i] !== exp_word || tin_hist[rd_cyc_q[i] + 2 + int'(h[i])] !== v[i]
            || wr_cyc_q[i] < rd_cyc_q[i] + 3 + int'(h[i])) begin
          fails++; $display("FAIL rand_vec%0d: got %h want %h", i, wr_data_q[i], exp_word);
        end
        if (i > 0) begin
          checks++;
          if (rd_cyc_q[i] != wr_cyc_q[i-1] + 1) begin
            fails++; $display("FAIL rand_refetch%0d: got %0d want %0d", i, rd_cyc_q[i], wr_cyc_q[i-1] + 1);
          end
        end
      end
    end
    checks++; if (int'(vec_count) != base + N) begin fails++; $display("FAIL rand_vec_count: got %0d want %0d", vec_count, base + N); end
    checks++; if (proto_err != 0) begin fails++; $display("FAIL protocol: got %0d violations want 0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold_max();
    test_wrfull();
    test_empty();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
